// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath and memory.
interface multicycle_controller_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite;
  logic        AdrSrc;
  logic        IRWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [2:0]  ImmSrc;
  logic        Illegal;
  logic [3:0]  State;

  modport master (
    input  Instr, Zero, MemReady,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, State
  );

  modport slave (
    output Instr, Zero, MemReady,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-FSM controller for a multicycle RV32 subset datapath.
// Define MULTICYCLE_MEM_READY_EN to stall FETCH/MEMREAD/MEMWRITE on MemReady.
module multicycle_controller (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_LUI      = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  state_t     state, state_next;
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       r_ok, i_ok;
  logic [2:0] r_alu, i_alu;
  logic       mem_ready;
  logic       pc_update, branch;
  logic       adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0] result_src, src_a, src_b;
  logic [2:0] alu_ctl;
  logic       unused_instr_bits;

  assign op = bus.Instr[6:0];
  assign f3 = bus.Instr[14:12];
  assign f7 = bus.Instr[31:25];
  assign unused_instr_bits = ^{bus.Instr[24:15], bus.Instr[11:7]};

`ifdef MULTICYCLE_MEM_READY_EN
  assign mem_ready = bus.MemReady;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.MemReady;
  assign mem_ready        = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Only the listed funct combinations are legal; anything else traps in DECODE.
  always_comb begin
    r_ok  = 1'b0;
    r_alu = ALU_ADD;
    case ({f7, f3})
      {7'h00, 3'b000}: begin r_ok = 1'b1; r_alu = ALU_ADD; end
      {7'h20, 3'b000}: begin r_ok = 1'b1; r_alu = ALU_SUB; end
      {7'h00, 3'b111}: begin r_ok = 1'b1; r_alu = ALU_AND; end
      {7'h00, 3'b110}: begin r_ok = 1'b1; r_alu = ALU_OR;  end
      {7'h00, 3'b010}: begin r_ok = 1'b1; r_alu = ALU_SLT; end
      default:         begin r_ok = 1'b0; r_alu = ALU_ADD; end
    endcase
    i_ok  = 1'b0;
    i_alu = ALU_ADD;
    case (f3)
      3'b000:  begin i_ok = 1'b1; i_alu = ALU_ADD; end
      3'b111:  begin i_ok = 1'b1; i_alu = ALU_AND; end
      3'b110:  begin i_ok = 1'b1; i_alu = ALU_OR;  end
      default: begin i_ok = 1'b0; i_alu = ALU_ADD; end
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   bus.ImmSrc = 3'b001;
      OP_BEQ:  bus.ImmSrc = 3'b010;
      OP_JAL:  bus.ImmSrc = 3'b011;
      OP_LUI:  bus.ImmSrc = 3'b100;
      default: bus.ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    state_next = state;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_ctl    = ALU_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        src_b      = 2'b10;
        result_src = 2'b10;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = (f3 == 3'b010) ? S_MEMADR : S_ILLEGAL;
          OP_R:         state_next = r_ok ? S_EXECUTER : S_ILLEGAL;
          OP_I:         state_next = i_ok ? S_EXECUTEI : S_ILLEGAL;
          OP_BEQ:       state_next = (f3 == 3'b000) ? S_BEQ : S_ILLEGAL;
          OP_JAL:       state_next = S_JAL;
          OP_JALR:      state_next = S_JALR;
          OP_LUI:       state_next = S_LUI;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        src_a      = 2'b10;
        alu_ctl    = r_alu;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        alu_ctl    = i_alu;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        src_a      = 2'b10;
        alu_ctl    = ALU_SUB;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      // JAL and JALRPC compute the link value OldPC+4 while ALUOut redirects the PC.
      S_JAL, S_JALRPC: begin
        src_a      = 2'b01;
        src_b      = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        state_next = S_JALRPC;
      end
      S_LUI: begin
        src_b      = 2'b01;
        alu_ctl    = ALU_PASS;
        state_next = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal    = 1'b1;
        state_next = S_ILLEGAL;
      end
      default: state_next = S_ILLEGAL;
    endcase
  end

  assign bus.PCWrite    = ~reset & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite    = ~reset & ir_write;
  assign bus.MemWrite   = ~reset & mem_write;
  assign bus.RegWrite   = ~reset & reg_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.Illegal    = illegal;
  assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction state paths and control
// words from an instruction-class model, plus reset and MemReady scenarios.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, irw, memw, regw;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu, imm;
    logic       ill;
  } ctl_t;

  typedef enum int {C_LW, C_SW, C_R, C_I, C_BEQ, C_JAL, C_JALR, C_LUI, C_BAD} cls_t;

  logic [3:0] path_q[$];

  function automatic ctl_t observed();
    observed = {bus.State, bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite,
                bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALUControl, bus.ImmSrc, bus.Illegal};
  endfunction

  function automatic cls_t classify(input logic [31:0] i);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    case (i[6:0])
      7'b0000011: return (f3 == 3'd2) ? C_LW : C_BAD;
      7'b0100011: return (f3 == 3'd2) ? C_SW : C_BAD;
      7'b0110011: begin
        if (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd2)) return C_R;
        if (f7 == 7'h20 && f3 == 3'd0) return C_R;
        return C_BAD;
      end
      7'b0010011: return (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6) ? C_I : C_BAD;
      7'b1100011: return (f3 == 3'd0) ? C_BEQ : C_BAD;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      default:    return C_BAD;
    endcase
  endfunction

  // Operation named by the mnemonic: add/sub/and/or/slt.
  function automatic logic [2:0] alu_of(input logic [31:0] i);
    case (i[14:12])
      3'd0:    return (i[6:0] == 7'b0110011 && i[30]) ? 3'b001 : 3'b000;
      3'd7:    return 3'b010;
      3'd6:    return 3'b011;
      3'd2:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [31:0] i);
    case (i[6:0])
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic void build_path(input logic [31:0] i);
    path_q = {};
    case (classify(i))
      C_LW:   path_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      C_SW:   path_q = {4'd0, 4'd1, 4'd2, 4'd5};
      C_R:    path_q = {4'd0, 4'd1, 4'd6, 4'd8};
      C_I:    path_q = {4'd0, 4'd1, 4'd7, 4'd8};
      C_BEQ:  path_q = {4'd0, 4'd1, 4'd9};
      C_JAL:  path_q = {4'd0, 4'd1, 4'd10, 4'd8};
      C_JALR: path_q = {4'd0, 4'd1, 4'd11, 4'd12, 4'd8};
      C_LUI:  path_q = {4'd0, 4'd1, 4'd13, 4'd8};
      default: begin
        path_q = {4'd0, 4'd1};
        for (int k = 0; k < 10; k++) path_q.push_back(4'd14);
      end
    endcase
  endfunction

  // Control word each state must present, written out from the state descriptions.
  function automatic ctl_t expect_ctl(input logic [3:0] st, input logic [31:0] i,
                                      input logic zero, input logic rst, input logic mr);
    ctl_t e;
    e     = '0;
    e.st  = st;
    e.imm = imm_of(i);
    case (st)
      4'd0:  begin e.irw = mr; e.pcw = mr; e.sb = 2'b10; e.rs = 2'b10; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3:  begin e.adr = 1'b1; end
      4'd4:  begin e.rs = 2'b01; e.regw = 1'b1; end
      4'd5:  begin e.adr = 1'b1; e.memw = 1'b1; end
      4'd6:  begin e.sa = 2'b10; e.alu = alu_of(i); end
      4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu_of(i); end
      4'd8:  begin e.regw = 1'b1; end
      4'd9:  begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = zero; end
      4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      4'd11: begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd12: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      4'd13: begin e.sb = 2'b01; e.alu = 3'b100; end
      4'd14: begin e.ill = 1'b1; end
      default: e = '0;
    endcase
    if (rst) begin
      e.pcw = 1'b0; e.irw = 1'b0; e.memw = 1'b0; e.regw = 1'b0;
    end
    return e;
  endfunction

  function automatic logic mem_ready_drive();
`ifdef MULTICYCLE_MEM_READY_EN
    return 1'b1;
`else
    return 1'($urandom_range(0, 1));
`endif
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic        good;
    int          k;
    i    = $urandom;
    good = ($urandom_range(0, 3) != 0);
    k    = $urandom_range(0, 8);
    case (k)
      0: begin i[6:0] = 7'b0000011; if (good) i[14:12] = 3'd2; end
      1: begin i[6:0] = 7'b0100011; if (good) i[14:12] = 3'd2; end
      2: begin
        i[6:0] = 7'b0110011;
        if (good) begin
          case ($urandom_range(0, 4))
            0: i[31:12] = {7'h00, i[24:15], 3'd0};
            1: i[31:12] = {7'h20, i[24:15], 3'd0};
            2: i[31:12] = {7'h00, i[24:15], 3'd7};
            3: i[31:12] = {7'h00, i[24:15], 3'd6};
            default: i[31:12] = {7'h00, i[24:15], 3'd2};
          endcase
        end
      end
      3: begin
        i[6:0] = 7'b0010011;
        if (good) begin
          case ($urandom_range(0, 2))
            0: i[14:12] = 3'd0;
            1: i[14:12] = 3'd7;
            default: i[14:12] = 3'd6;
          endcase
        end
      end
      4: begin i[6:0] = 7'b1100011; if (good) i[14:12] = 3'd0; end
      5: i[6:0] = 7'b1101111;
      6: begin i[6:0] = 7'b1100111; i[14:12] = 3'd0; end
      7: i[6:0] = 7'b0110111;
      default: ;
    endcase
    return i;
  endfunction

  // Runs one instruction from FETCH; an illegal one is cleared by a one-cycle reset.
  task automatic drive_instr(input logic [31:0] i, input logic zero);
    ctl_t e, o;
    bus.Instr = i;
    bus.Zero  = zero;
    build_path(i);
    foreach (path_q[k]) begin
      bus.MemReady = mem_ready_drive();
      #1;
      e = expect_ctl(path_q[k], i, zero, 1'b0, 1'b1);
      o = observed();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL step instr=%h k=%0d got=%h want=%h", i, k, o, e);
      end
      @(negedge clk);
    end
    if (path_q[path_q.size()-1] == 4'd14) begin
      reset = 1'b1;
      #1;
      e = expect_ctl(4'd14, i, zero, 1'b1, 1'b1);
      o = observed();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL illegal_reset instr=%h got=%h want=%h", i, o, e);
      end
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  task automatic test_reset();
    ctl_t e, o;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      e = expect_ctl(4'd0, bus.Instr, bus.Zero, 1'b1, 1'b1);
      o = observed();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset cycle=%0d got=%h want=%h", c, o, e);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    drive_instr({7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011}, 1'b0);
    #1;
    total++;
    if (bus.State !== 4'd0) begin
      bad++;
      $display("FAIL add_next_state got=%0d want=0", bus.State);
    end
  endtask

  task automatic test_beq();
    drive_instr({7'h00, 5'd2, 5'd1, 3'd0, 5'd8, 7'b1100011}, 1'b1);
    drive_instr({7'h00, 5'd2, 5'd1, 3'd0, 5'd8, 7'b1100011}, 1'b0);
    #1;
    total++;
    if (bus.State !== 4'd0) begin
      bad++;
      $display("FAIL beq_next_state got=%0d want=0", bus.State);
    end
  endtask

  task automatic test_illegal();
    drive_instr(32'h0000_007F, 1'b0);
    #1;
    total++;
    if (bus.State !== 4'd0 || bus.Illegal !== 1'b0) begin
      bad++;
      $display("FAIL illegal_recover got state=%0d ill=%b want state=0 ill=0", bus.State, bus.Illegal);
    end
  endtask

  task automatic test_jalr();
    drive_instr({12'h010, 5'd1, 3'd0, 5'd1, 7'b1100111}, 1'b0);
  endtask

  task automatic test_reset_mid_lw();
    logic [31:0] i;
    ctl_t        e, o;
    logic        regw_seen;
    i = {12'h004, 5'd2, 3'd2, 5'd5, 7'b0000011};
    regw_seen = 1'b0;
    bus.Instr = i;
    bus.MemReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) reset = 1'b1;
      #1;
      e = expect_ctl(4'(k), i, 1'b0, (k == 3), 1'b1);
      o = observed();
      regw_seen |= bus.RegWrite;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL lw_reset step=%0d got=%h want=%h", k, o, e);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    regw_seen |= bus.RegWrite;
    total++;
    if (bus.State !== 4'd0 || regw_seen !== 1'b0) begin
      bad++;
      $display("FAIL lw_reset_abort got state=%0d regw_seen=%b want state=0 regw_seen=0", bus.State, regw_seen);
    end
  endtask

  task automatic test_back_to_back();
    drive_instr({12'h008, 5'd2, 3'd2, 5'd6, 7'b0100011}, 1'b0);
    drive_instr({12'h00C, 5'd2, 3'd2, 5'd6, 7'b0000011}, 1'b0);
    drive_instr({20'h12345, 5'd7, 7'b0110111}, 1'b0);
    drive_instr({20'h00100, 5'd1, 7'b1101111}, 1'b0);
    drive_instr({12'hFFF, 5'd4, 3'd6, 5'd4, 7'b0010011}, 1'b0);
    drive_instr({7'h00, 5'd2, 5'd1, 3'd2, 5'd3, 7'b0110011}, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) drive_instr(rand_instr(), 1'($urandom_range(0, 1)));
  endtask

`ifdef MULTICYCLE_MEM_READY_EN
  task automatic test_mem_ready();
    logic [31:0] i;
    logic [3:0]  sts[$];
    logic        mrs[$];
    ctl_t        e, o;
    i = {12'h010, 5'd2, 3'd2, 5'd9, 7'b0100011};
    sts = {4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    mrs = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.Instr = i;
    bus.Zero  = 1'b0;
    foreach (sts[k]) begin
      bus.MemReady = mrs[k];
      #1;
      e = expect_ctl(sts[k], i, 1'b0, 1'b0, mrs[k]);
      o = observed();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL memready_sw step=%0d got=%h want=%h", k, o, e);
      end
      @(negedge clk);
    end
    i = {12'h014, 5'd2, 3'd2, 5'd9, 7'b0000011};
    sts = {4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    mrs = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.Instr = i;
    foreach (sts[k]) begin
      bus.MemReady = mrs[k];
      #1;
      e = expect_ctl(sts[k], i, 1'b0, 1'b0, mrs[k]);
      o = observed();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL memready_lw step=%0d got=%h want=%h", k, o, e);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    reset        = 1'b1;
    bus.Instr    = 32'h0000_0013;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b1;
    test_reset();
    test_add();
    test_beq();
    test_illegal();
    test_jalr();
    test_reset_mid_lw();
    test_back_to_back();
`ifdef MULTICYCLE_MEM_READY_EN
    test_mem_ready();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 Instr  input  32  instruction register contents; opcode [6:0], funct3 [14:12], funct7 [31:25].
REQ-004 Zero  input  1  ALU zero flag.
REQ-005 MemReady  input  1  memory handshake; sampled only when MULTICYCLE_MEM_READY_EN is defined.
REQ-006 PCWrite  output  1  PC register enable; equals PCUpdate | (Branch & Zero).
REQ-007 AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
REQ-008 IRWrite  output  1  instruction/OldPC register enable.
REQ-009 MemWrite, RegWrite  output  1 each  data memory and register file write enables.
REQ-010 ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-011 ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A; ALUSrcB  output  2  00 = B, 01 = ImmExt, 10 = constant 4.
REQ-012 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 100 pass SrcB.
REQ-013 ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U; decoded combinationally from opcode in every state.
REQ-014 Illegal  output  1  high while in ILLEGAL state; State  output  4  current state encoding.

Function
REQ-015 The block SHALL be a Moore FSM with these encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, JALR 11, JALRPC 12, LUI 13, ILLEGAL 14.
REQ-016 FETCH SHALL assert AdrSrc=0, IRWrite, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCUpdate, then go to DECODE.
REQ-017 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut); next: lw→MEMADR, sw→MEMADR, R→EXECUTER, I-ALU→EXECUTEI, beq→BEQ, jal→JAL, jalr→JALR, lui→LUI, else→ILLEGAL.
REQ-018 MEMADR: SrcA=10, SrcB=01, add; to MEMREAD for lw, MEMWRITE for sw.
REQ-019 MEMREAD: AdrSrc=1, ResultSrc=00 → MEMWB; MEMWB: ResultSrc=01, RegWrite → FETCH.
REQ-020 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite → FETCH.
REQ-021 EXECUTER: SrcA=10, SrcB=00, funct-decoded op; EXECUTEI: SrcA=10, SrcB=01, funct-decoded op; both → ALUWB. ALUWB: ResultSrc=00, RegWrite → FETCH.
REQ-022 BEQ: SrcA=10, SrcB=00, sub, ResultSrc=00, Branch → FETCH.
REQ-023 JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCUpdate → ALUWB (rd = OldPC+4, PC = target).
REQ-024 JALR: SrcA=10, SrcB=01, add → JALRPC; JALRPC: SrcA=01, SrcB=10, add, ResultSrc=00, PCUpdate → ALUWB.
REQ-025 LUI: SrcB=01, ALUControl=100 → ALUWB.
REQ-026 Supported functs only: R add/sub/and/or/slt, I addi/andi/ori, lw/sw funct3=010, beq funct3=000; any other funct in DECODE SHALL go to ILLEGAL.
REQ-027 ILLEGAL SHALL deassert all write enables, assert Illegal, and hold until reset.
REQ-028 Latency (cycles incl. FETCH): beq 3; R, I, sw, jal, lui 4; lw, jalr 5.
REQ-029 Unlisted outputs in any state SHALL be 0; no X driven.

Reset
REQ-030 While reset is high at a clock edge, the next state SHALL be FETCH regardless of current state, including mid-instruction or ILLEGAL.
REQ-031 While reset is high, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced 0.

Configuration
REQ-032 Macro MULTICYCLE_MEM_READY_EN: when defined, FETCH, MEMREAD and MEMWRITE SHALL hold state while MemReady=0, with IRWrite/PCWrite in FETCH gated by MemReady and MemWrite held asserted throughout MEMWRITE.
REQ-033 When undefined, MemReady SHALL be ignored and every state SHALL last exactly one cycle.

Verification
REQ-034 reset for 2 cycles then add x3,x1,x2 → states 0,1,6,8; RegWrite=1 only in state 8; State=0 next.
REQ-035 beq with Zero=1 in BEQ → PCWrite=1 that cycle; with Zero=0 → PCWrite=0; 3 cycles each.
REQ-036 Instr=0x0000007F (bad opcode) → DECODE→ILLEGAL, Illegal=1, all enables 0 for 10 cycles; reset → FETCH.
REQ-037 With macro: sw, MemReady=0 for 3 cycles in MEMWRITE → State=5 held, MemWrite=1 for 4 cycles; MemReady=1 → FETCH.
REQ-038 reset asserted in MEMREAD of lw → next State=0, RegWrite never asserted for that lw.
REQ-039 jalr sequence → states 0,1,11,12,8; PCWrite=1 only in 12 (and 0).
